// File: rtl/param_logic_unit.sv
// param_logic_unit: registered bitwise logic unit with accumulator and valid/ready handshakes.
//
// Ports:
//   clk        - system clock, all state updates on the rising edge
//   rst_n      - synchronous active-low reset
//   in_valid   - upstream presents an operation
//   in_ready   - unit can accept an operation this cycle
//   a, b       - operands (WIDTH bits)
//   sel        - operation: 0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 NOT B
//   acc_mode   - replace operand B with the accumulator
//   clear_acc  - clear the accumulator (an accept in the same cycle wins)
//   out_valid  - out holds an undelivered result
//   out_ready  - downstream takes the result this cycle
//   out        - registered result
//   op_count   - accepted operations, modulo 256
module param_logic_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    input  logic             acc_mode,
    input  logic             clear_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [7:0]       op_count
);
    logic [WIDTH-1:0] out_q, out_d, acc_q, acc_d, b_eff, res;
    logic             valid_q, valid_d, accept;
    logic [7:0]       cnt_q, cnt_d;

    // A pending clear zeroes the accumulator operand so the result reflects the clear.
    assign b_eff    = acc_mode ? (clear_acc ? '0 : acc_q) : b;
    assign in_ready = rst_n & (~valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        res = '0;
        case (sel)
            3'd0: res = ~(a & b_eff);
            3'd1: res = a & b_eff;
            3'd2: res = a | b_eff;
            3'd3: res = ~(a | b_eff);
            3'd4: res = a ^ b_eff;
            3'd5: res = ~(a ^ b_eff);
            3'd6: res = ~a;
            default: res = ~b_eff;
        endcase
    end

    always_comb begin
        out_d   = accept ? res : out_q;
        valid_d = accept ? 1'b1 : (out_ready ? 1'b0 : valid_q);
        acc_d   = accept ? res : (clear_acc ? '0 : acc_q);
        cnt_d   = accept ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign op_count  = cnt_q;
endmodule

// File: tb/tb_param_logic_unit.sv
// tb_param_logic_unit: table-driven and scoreboard checks for param_logic_unit (WIDTH=8).
module tb_param_logic_unit;
    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, acc_mode, clear_acc, out_valid, out_ready;
    logic [7:0] a, b, out, op_count;
    logic [2:0] sel;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sel;
        logic       am;
        logic       cl;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[14];

    param_logic_unit #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .acc_mode(acc_mode), .clear_acc(clear_acc),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: a delivery happens on the next edge whenever out_valid & out_ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got %0h expected none", out);
            end else begin
                check("result", out, sb.pop_front());
            end
        end
    end

    task automatic op(input logic [7:0] ia, ib, input logic [2:0] is, input logic am, cl,
                      input logic [7:0] e, output int w);
        a = ia; b = ib; sel = is; acc_mode = am; clear_acc = cl; in_valid = 1'b1; w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end else begin
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; acc_mode = 1'b0; clear_acc = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("in_ready_in_reset", in_ready, 0);
        @(posedge clk); #1;
        check("rst_out", out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_op_count", op_count, 0);
        rst_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        int w;
        logic [7:0] cnt;
        vecs[0]  = '{8'hF0, 8'hCC, 3'd0, 1'b0, 1'b0, 8'h3F};
        vecs[1]  = '{8'hF0, 8'hCC, 3'd1, 1'b0, 1'b0, 8'hC0};
        vecs[2]  = '{8'hF0, 8'hCC, 3'd2, 1'b0, 1'b0, 8'hFC};
        vecs[3]  = '{8'hF0, 8'hCC, 3'd3, 1'b0, 1'b0, 8'h03};
        vecs[4]  = '{8'hF0, 8'hCC, 3'd4, 1'b0, 1'b0, 8'h3C};
        vecs[5]  = '{8'hF0, 8'hCC, 3'd5, 1'b0, 1'b0, 8'hC3};
        vecs[6]  = '{8'hF0, 8'hCC, 3'd6, 1'b0, 1'b0, 8'h0F};
        vecs[7]  = '{8'hF0, 8'hCC, 3'd7, 1'b0, 1'b0, 8'h33};
        vecs[8]  = '{8'h01, 8'hFF, 3'd4, 1'b1, 1'b0, 8'h01};
        vecs[9]  = '{8'h01, 8'hFF, 3'd4, 1'b1, 1'b0, 8'h00};
        vecs[10] = '{8'h01, 8'hFF, 3'd4, 1'b1, 1'b0, 8'h01};
        vecs[11] = '{8'h80, 8'h7F, 3'd2, 1'b1, 1'b1, 8'h80};
        vecs[12] = '{8'h00, 8'h00, 3'd2, 1'b1, 1'b0, 8'h80};
        vecs[13] = '{8'h0F, 8'hAA, 3'd7, 1'b1, 1'b0, 8'h7F};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sel = '0;
        acc_mode = 1'b0; clear_acc = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("init_out", out, 0);
        check("init_out_valid", out_valid, 0);
        check("init_op_count", op_count, 0);
        check("init_in_ready", in_ready, 0);
        rst_n = 1'b1;

        // Full-throughput sweep of all operations, starting on the first edge out of reset.
        for (int i = 0; i < 8; i++) begin
            op(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].am, vecs[i].cl, vecs[i].exp, w);
            check("sweep_no_stall", w, 0);
            check("sweep_out_valid", out_valid, 1);
        end
        drain();
        check("sweep_op_count", op_count, 8);

        // Accumulator feedback, clear-with-accept, and readback of acc through an OR with zero.
        do_reset();
        for (int i = 8; i < 14; i++) begin
            op(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].am, vecs[i].cl, vecs[i].exp, w);
        end
        drain();

        // Standalone clear: acc=5A then clear with no accept.
        op(8'h5A, 8'h00, 3'd2, 1'b0, 1'b0, 8'h5A, w);
        drain();
        cnt = op_count;
        clear_acc = 1'b1;
        @(posedge clk); #1;
        clear_acc = 1'b0;
        check("clear_keeps_out", out, 8'h5A);
        check("clear_keeps_count", op_count, cnt);
        op(8'h00, 8'hFF, 3'd2, 1'b1, 1'b0, 8'h00, w);
        drain();

        // Back-pressure: hold FF for 4 cycles, then deliver and accept in the same cycle.
        op(8'hAA, 8'h55, 3'd2, 1'b0, 1'b0, 8'hFF, w);
        out_ready = 1'b0;
        cnt = op_count;
        a = 8'h0F; b = 8'hF0; sel = 3'd1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_out", out, 8'hFF);
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_op_count", op_count, cnt);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        op(8'h0F, 8'hF0, 3'd1, 1'b0, 1'b0, 8'h00, w);
        check("release_same_cycle", w, 0);
        check("release_op_count", op_count, cnt + 8'd1);
        drain();

        // op_count wrap.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i);
            op(v, 8'h00, 3'd6, 1'b0, 1'b0, ~v, w);
            if (i == 254) check("count_255", op_count, 255);
        end
        check("count_wrap_0", op_count, 0);
        op(8'h12, 8'h34, 3'd4, 1'b0, 1'b0, 8'h26, w);
        check("count_wrap_1", op_count, 1);
        drain();

        // Reset with a pending result discards it and clears acc.
        out_ready = 1'b0;
        op(8'hF0, 8'hCC, 3'd4, 1'b0, 1'b0, 8'h3C, w);
        check("pending_out", out, 8'h3C);
        check("pending_valid", out_valid, 1);
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);
        @(posedge clk); #1;
        check("no_late_delivery", out_valid, 0);
        op(8'h00, 8'hFF, 3'd2, 1'b1, 1'b0, 8'h00, w);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/param_logic_unit.md
PARAM_LOGIC_UNIT -- requirements
Module: param_logic_unit

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal range 1..64).
REQ-002 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port in_valid  input  1  upstream presents an operation.
REQ-005 Port in_ready  output  1  unit can accept an operation this cycle.
REQ-006 Port a  input  WIDTH  operand A.
REQ-007 Port b  input  WIDTH  operand B.
REQ-008 Port sel  input  3  operation select.
REQ-009 Port acc_mode  input  1  when high, operand B is replaced by the accumulator.
REQ-010 Port clear_acc  input  1  synchronous accumulator clear request.
REQ-011 Port out_valid  output  1  out holds an undelivered result.
REQ-012 Port out_ready  input  1  downstream accepts the result this cycle.
REQ-013 Port out  output  WIDTH  registered result.
REQ-014 Port op_count  output  8  number of accepted operations, modulo 256.

Function
REQ-015 Bitwise op per sel, applied on every bit: 0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 NOT B.
REQ-016 Effective B SHALL be b when acc_mode=0, acc when acc_mode=1 and clear_acc=0, and all-zeros when acc_mode=1 and clear_acc=1.
REQ-017 Accept event: in_valid & in_ready on a rising edge.
REQ-018 in_ready SHALL equal rst_n & (~out_valid | out_ready), combinationally; no dependence on in_valid.
REQ-019 On accept, out SHALL load the result and out_valid SHALL be 1 on the next cycle (latency 1 cycle).
REQ-020 While out_valid=1 and out_ready=0, out and out_valid SHALL hold unchanged.
REQ-021 When out_valid=1, out_ready=1 and no accept, out_valid SHALL clear next cycle; out holds its last value.
REQ-022 Simultaneous delivery and accept: out SHALL load the new result and out_valid SHALL stay 1 (full throughput, one op per cycle).
REQ-023 Internal WIDTH-bit accumulator acc SHALL load the result on every accept, regardless of acc_mode.
REQ-024 clear_acc=1 with no accept SHALL set acc to 0 next cycle.
REQ-025 clear_acc=1 with an accept SHALL load acc with the result computed using REQ-016 (the result wins over the clear).
REQ-026 clear_acc SHALL NOT affect out, out_valid or op_count.
REQ-027 op_count SHALL increment by 1 on every accept and wrap from 255 to 0.
REQ-028 Inputs a, b, sel, acc_mode are don't-care when no accept occurs; no state changes from them.

Reset
REQ-029 While rst_n=0 at a rising edge: out=0, out_valid=0, acc=0, op_count=0.
REQ-030 in_ready SHALL be 0 whenever rst_n=0.
REQ-031 Reset asserted with a result pending SHALL discard that result; no partial delivery after reset.
REQ-032 First accept is possible on the first edge with rst_n=1.

Verification (WIDTH=8)
REQ-033 Release reset, out_ready=1; accept a=8'hF0, b=8'hCC with sel=0..7 on consecutive cycles -> out sequence 3F,C0,FC,03,3C,C3,0F,33, one per cycle, out_valid held 1, op_count=8.
REQ-034 acc_mode=1, sel=4, a=8'h01 for 3 accepts after reset -> out 01,00,01; then clear_acc=1 with sel=2, a=8'h80 -> out=80, and acc=80.
REQ-035 Accept a=8'hAA, b=8'h55, sel=2, then hold out_ready=0 for 4 cycles with in_valid=1 -> out=FF stable, out_valid=1, in_ready=0, op_count unchanged; release -> next op accepted in the same cycle as delivery.
REQ-036 Issue 256 accepts -> op_count returns to 0; 257th -> 1.
REQ-037 Pending out=8'h3C with out_ready=0, assert rst_n=0 one cycle -> out=0, out_valid=0, op_count=0, acc=0; in_ready=0 during reset, 1 after.
REQ-038 clear_acc=1 alone with acc=8'h5A -> acc=0, verified by next acc_mode=1, sel=2, a=0 accept yielding out=00.
